// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: fetch FSM states, datapath widths, reset PC and opcodes.
package kgp_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      ISSUE  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   localparam int          PC_STEP  = 4;
   localparam int          OFFSET_W = 26;
   localparam int          INSTR_W  = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // Opcode field values shared with the branch logic.
   localparam logic [5:0] OPC_ALU    = 6'b000000;
   localparam logic [5:0] OPC_BRANCH = 6'b000011;
   localparam logic [5:0] OPC_JR     = 6'b000100;
   localparam logic [5:0] OPC_HALT   = 6'b111111;

   function automatic logic is_control_op(input logic [5:0] opcode);
      return (opcode == OPC_BRANCH) || (opcode == OPC_JR) || (opcode == OPC_HALT);
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-fetch-address selection: register jump, PC-relative branch or sequential step.
module next_pc_calc
   import kgp_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int STEP   = kgp_pkg::PC_STEP
) (
   input  logic [ADDR_W-1:0]   instr_pc,
   input  logic                branch,
   input  logic [OFFSET_W-1:0] offset_in,
   input  logic                jr_valid,
   input  logic [ADDR_W-1:0]   jr_target,
   output logic [ADDR_W-1:0]   next_pc
);

   logic [ADDR_W-1:0] offset_ext;
   logic [ADDR_W-1:0] seq_pc;

   always_comb begin
      offset_ext = {{(ADDR_W-OFFSET_W){offset_in[OFFSET_W-1]}}, offset_in};
      seq_pc     = instr_pc + ADDR_W'(STEP);
      next_pc    = seq_pc;
      // Jump targets are word aligned; low bits of the register are dropped.
      if (jr_valid) begin
         next_pc = jr_target & ~ADDR_W'(3);
      end else if (branch) begin
         next_pc = seq_pc + (offset_ext << 2);
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// KGP-RISC program counter and instruction fetch stage, one instruction in flight.
// Optional FETCH_PERF_EN adds fetch_count / taken_count performance counters.
module fetch_pc_unit
   import kgp_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(kgp_pkg::RESET_PC),
   parameter int                PC_STEP  = kgp_pkg::PC_STEP
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                branch,
   input  logic [OFFSET_W-1:0] offset_in,
   input  logic                jr_valid,
   input  logic [ADDR_W-1:0]   jr_target,
   input  logic                halt,
   output logic                halted,
`ifdef FETCH_PERF_EN
   output logic [31:0]         fetch_count,
   output logic [31:0]         taken_count,
`endif
   output fetch_state_e        dbg_state
);

   // Handshakes: memory transfer happens on a cycle with imem_req & imem_ack
   // (req holds until then); decode transfer happens on instr_valid & instr_ready,
   // with instr/instr_pc held stable while valid is high and ready is low.

   fetch_state_e      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] next_pc;
   logic              accept;

   assign accept    = instr_valid & instr_ready;
   assign imem_addr = pc;
   assign dbg_state = state;

   next_pc_calc #(
      .ADDR_W (ADDR_W),
      .STEP   (PC_STEP)
   ) u_next_pc (
      .instr_pc  (instr_pc),
      .branch    (branch),
      .offset_in (offset_in),
      .jr_valid  (jr_valid),
      .jr_target (jr_target),
      .next_pc   (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
`ifdef FETCH_PERF_EN
         fetch_count <= '0;
         taken_count <= '0;
`endif
      end else begin
         case (state)
            FETCH: begin
               // req is low only on the first cycle after reset, so a stale ack is dropped.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (accept) begin
`ifdef FETCH_PERF_EN
                  fetch_count <= fetch_count + 32'd1;
                  if (branch || jr_valid) taken_count <= taken_count + 32'd1;
`endif
                  instr_valid <= 1'b0;
                  if (halt) begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     pc       <= next_pc;
                     imem_req <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            HALTED: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end
            default: begin
               state    <= FETCH;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit; define FETCH_PERF_EN to also check the counters.
module tb_fetch_pc_unit;
   import kgp_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               imem_req;
   logic [31:0]        imem_addr;
   logic               imem_ack = 1'b0;
   logic [31:0]        imem_rdata = '0;
   logic [31:0]        instr;
   logic [31:0]        instr_pc;
   logic               instr_valid;
   logic               instr_ready = 1'b0;
   logic               branch = 1'b0;
   logic [25:0]        offset_in = '0;
   logic               jr_valid = 1'b0;
   logic [31:0]        jr_target = '0;
   logic               halt = 1'b0;
   logic               halted;
`ifdef FETCH_PERF_EN
   logic [31:0]        fetch_count;
   logic [31:0]        taken_count;
`endif
   fetch_state_e       dbg_state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch      (branch),
      .offset_in   (offset_in),
      .jr_valid    (jr_valid),
      .jr_target   (jr_target),
      .halt        (halt),
      .halted      (halted),
`ifdef FETCH_PERF_EN
      .fetch_count (fetch_count),
      .taken_count (taken_count),
`endif
      .dbg_state   (dbg_state)
   );

   // Driver: wait for a request, check its address, ack after 'delay' cycles, check the held instruction.
   task automatic fetch_word(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
      end
      checks++;
      if (imem_addr !== exp_addr) begin
         errors++;
         $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_addr);
      end
      repeat (delay) @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack   = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr !== word || instr_pc !== exp_addr) begin
         errors++;
         $display("FAIL fetch_issue: valid=%b instr=%h pc=%h required 1 %h %h",
                  instr_valid, instr, instr_pc, word, exp_addr);
      end
   endtask

   // Driver: accept the held instruction with the given control inputs and check the next fetch.
   task automatic accept_instr(input logic br, input logic [25:0] off, input logic jr,
                               input logic [31:0] tgt, input logic hlt, input logic [31:0] exp_next);
      instr_ready = 1'b1;
      branch      = br;
      offset_in   = off;
      jr_valid    = jr;
      jr_target   = tgt;
      halt        = hlt;
      @(negedge clk);
      instr_ready = 1'b0;
      branch      = 1'b0;
      offset_in   = '0;
      jr_valid    = 1'b0;
      jr_target   = '0;
      halt        = 1'b0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL accept_valid_drop: instr_valid=%b required 0", instr_valid);
      end
      checks++;
      if (hlt) begin
         if (halted !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL accept_halt: halted=%b imem_req=%b required 1 0", halted, imem_req);
         end
      end else if (imem_req !== 1'b1 || imem_addr !== exp_next) begin
         errors++;
         $display("FAIL accept_next_pc: imem_req=%b imem_addr=%h required 1 %h",
                  imem_req, imem_addr, exp_next);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
          instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_values: req=%b valid=%b halted=%b instr=%h ipc=%h addr=%h required all 0",
                  imem_req, instr_valid, halted, instr, instr_pc, imem_addr);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: fetch=%0d taken=%0d required 0 0", fetch_count, taken_count);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_req: imem_req=%b required 1", imem_req);
      end
      fetch_word(32'h0, 32'h1234_5678, 0);
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b0, 32'h4);
   endtask

   task automatic test_branch;
      fetch_word(32'h4, 32'h0000_0001, 1);
      accept_instr(1'b0, 26'd0, 1'b1, 32'h40, 1'b0, 32'h40);
      fetch_word(32'h40, 32'h0C00_0008, 0);
      accept_instr(1'b1, 26'd8, 1'b0, 32'h0, 1'b0, 32'h64);
      fetch_word(32'h64, 32'h1000_0000, 0);
      accept_instr(1'b0, 26'd0, 1'b1, 32'h40, 1'b0, 32'h40);
      fetch_word(32'h40, 32'h0FFF_FFFE, 2);
      accept_instr(1'b1, 26'h3FF_FFFE, 1'b0, 32'h0, 1'b0, 32'h3C);
   endtask

   task automatic test_jr_priority;
      fetch_word(32'h3C, 32'h1000_0103, 0);
      accept_instr(1'b1, 26'd4, 1'b1, 32'h103, 1'b0, 32'h100);
   endtask

   task automatic test_stall;
      fetch_word(32'h100, 32'hCAFE_F00D, 0);
      for (int i = 0; i < 5; i++) begin
         branch    = i[0];
         offset_in = 26'd16;
         jr_valid  = ~i[0];
         jr_target = 32'h800;
         halt      = i[0];
         @(negedge clk);
         checks++;
         if (instr !== 32'hCAFE_F00D || instr_pc !== 32'h100 || imem_req !== 1'b0 ||
             instr_valid !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: instr=%h pc=%h req=%b valid=%b halted=%b required cafef00d 100 0 1 0",
                     i, instr, instr_pc, imem_req, instr_valid, halted);
         end
      end
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b0, 32'h104);
   endtask

   task automatic test_wrap_halt;
      fetch_word(32'h104, 32'h1000_0000, 0);
      accept_instr(1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
      fetch_word(32'hFFFF_FFFC, 32'h0000_0002, 0);
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      fetch_word(32'h0, 32'hFC00_0000, 0);
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b1, 32'h0);
      for (int i = 0; i < 6; i++) begin
         imem_ack    = i[0];
         instr_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL halted_hold[%0d]: halted=%b req=%b valid=%b addr=%h required 1 0 0 0",
                     i, halted, imem_req, instr_valid, imem_addr);
         end
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fetch_word(32'h0, 32'hAAAA_5555, 0);
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b0, 32'h4);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
          instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_async: req=%b valid=%b halted=%b instr=%h ipc=%h addr=%h required all 0",
                  imem_req, instr_valid, halted, instr, instr_pc, imem_addr);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_async_counters: fetch=%0d taken=%0d required 0 0", fetch_count, taken_count);
      end
`endif
      @(negedge clk);
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack   = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL late_ack: valid=%b req=%b addr=%h required 0 1 0", instr_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_back_to_back;
      fetch_word(32'h0, 32'h0C00_0001, 0);
      accept_instr(1'b1, 26'd1, 1'b0, 32'h0, 1'b0, 32'h8);
      fetch_word(32'h8, 32'h0000_0003, 0);
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b0, 32'hC);
      fetch_word(32'hC, 32'h0000_0004, 0);
      accept_instr(1'b0, 26'd0, 1'b0, 32'h0, 1'b0, 32'h10);
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== 32'd3 || taken_count !== 32'd1) begin
         errors++;
         $display("FAIL perf_counts: fetch=%0d taken=%0d required 3 1", fetch_count, taken_count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jr_priority();
      test_stall();
      test_wrap_halt();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage of the KGP-RISC core.
- Upstream of the branch logic: supplies the held instruction (opcode, offset field) to decode and branch logic.
- Consumes the branch logic's branch and offset_out results, plus register-jump targets, to choose the next fetch address.
- Talks to instruction memory over a req/ack handshake and to decode over a valid/ready handshake.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  ADDR_W  fetch address, equals pc while imem_req=1.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction to decode.
- instr_pc  out  ADDR_W  address of held instruction.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts the held instruction.
- branch  in  1  branch taken for the instruction being accepted (from branch logic).
- offset_in  in  26  signed word offset for the branch (branch logic offset_out).
- jr_valid  in  1  register jump for the instruction being accepted.
- jr_target  in  ADDR_W  absolute register-jump target.
- halt  in  1  accepted instruction is HALT.
- halted  out  1  fetch stopped.

Behaviour:
- Reset values (asynchronous on rst=1): pc=RESET_PC, state=FETCH, imem_req=0, instr=0, instr_pc=0, instr_valid=0, halted=0.
- imem_req goes high in the first cycle after rst deasserts.
- FETCH state:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, go to ISSUE.
  - An ack in the same cycle imem_req first rises is legal.
- ISSUE state:
  - imem_req=0, instr_valid=1; instr and instr_pc are stable until accepted.
  - Accept = instr_valid & instr_ready.
  - On accept, next pc priority, highest first:
    - halt -> go to HALTED, pc unchanged.
    - jr_valid -> jr_target.
    - branch -> instr_pc + PC_STEP + (sign_extend(offset_in) << 2).
    - otherwise instr_pc + PC_STEP.
  - After a non-halt accept: instr_valid<=0, go to FETCH.
- HALTED state: halted=1, imem_req=0, instr_valid=0. Only rst leaves this state.
- Control inputs sampled only at accept: branch, jr_valid and halt are ignored in any other cycle.
- Throughput: minimum 2 cycles per instruction (no prefetch), so no speculative fetch and no flush logic.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W; wrap-around is silent. The offset is sign-extended from bit 25.
- Alignment: jr_target bits[1:0] are forced to 0.
- imem_ack outside FETCH is ignored.
- Reset in mid-operation: rst during FETCH or ISSUE discards any in-flight request and held instruction. A late ack after reset is ignored until the new FETCH begins.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, the block adds:
  - Output fetch_count (32): increments on every accept.
  - Output taken_count (32): increments on accept with branch|jr_valid.
  - Both counters reset to 0 asynchronously and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package kgp_pkg:
  - Fetch state enum {FETCH, ISSUE, HALTED}.
  - Constants: PC_STEP, OFFSET_W=26, INSTR_W=32, RESET_PC.
  - Opcode constants already used by the branch logic.
- One natural sub-module, next_pc_calc: combinational next-pc mux and adder with sign-extension. The FSM and registers stay in fetch_pc_unit.

Test Plan:
- Reset then immediate ack with imem_rdata=32'h1234_5678 -> imem_addr=0; instr_valid=1 next cycle with instr=32'h1234_5678, instr_pc=0; on accept with no branch, next imem_addr=4.
- instr_pc=32'h40, accept with branch=1, offset_in=26'd8 -> next imem_addr=32'h64. Repeat with offset_in=-2 (26'h3FFFFFE) -> 32'h3C.
- Accept with jr_valid=1, jr_target=32'h103, branch=1, offset_in=4 -> jr wins, imem_addr=32'h100.
- Hold instr_ready=0 for 5 cycles and toggle branch=1 during the wait -> instr stable, imem_req=0, branch ignored; accept without branch -> pc+4.
- Wrap: instr_pc=32'hFFFF_FFFC, accept without branch -> imem_addr=0. Accept with halt=1 -> halted=1, no further imem_req until rst.
- Delay imem_ack 3 cycles and assert rst mid-wait -> outputs return to reset values immediately; fetch restarts at RESET_PC. Under FETCH_PERF_EN, counters read 0 after reset and 3/1 after three accepts with one taken branch.
